// File: rtl/digital_clock_pkg.sv
// Shared constants and types for the digital_clock time-of-day counter.
// The 12-hour helper is only used when DIGITAL_CLOCK_12H_EN is defined.
package digital_clock_pkg;

  localparam int unsigned TIME_W   = 6;
  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned HOUR_MOD = 24;

  typedef logic [TIME_W-1:0] time_field_t;

  // Map an internal 0..23 hour onto the 1..12 dial.
  function automatic time_field_t to_12h(input time_field_t hour24);
    if (hour24 == '0) begin
      return time_field_t'(12);
    end else if (hour24 > time_field_t'(12)) begin
      return hour24 - time_field_t'(12);
    end else begin
      return hour24;
    end
  endfunction

endpackage

// File: rtl/clock_mod_counter.sv
// Modulo-MOD up/down counter with synchronous active-low clear.
// wrap flags an increment that rolls MOD-1 over to 0 (the carry out).
module clock_mod_counter
  import digital_clock_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              inc,
  input  logic              dec,
  output logic [TIME_W-1:0] count,
  output logic              wrap
);

  localparam time_field_t MaxVal = time_field_t'(MOD - 1);

  time_field_t count_q, count_d;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (inc && !dec) begin
      if (count_q == MaxVal) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + time_field_t'(1);
      end
    end else if (dec && !inc) begin
      if (count_q == '0) begin
        count_d = MaxVal;
      end else begin
        count_d = count_q - time_field_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/digital_clock.sv
// 24-hour hh:mm:ss counter on a 1 Hz clock with button setting while stopped.
// Optional DIGITAL_CLOCK_12H_EN adds a pm output and a 1..12 hours display.
module digital_clock
  import digital_clock_pkg::*;
(
  input  logic              Clk_1sec,
  input  logic              reset,
  input  logic              clock_enable,
  input  logic              min_inc,
  input  logic              min_dec,
  input  logic              hour_inc,
  input  logic              hour_dec,
  output logic [TIME_W-1:0] seconds,
  output logic [TIME_W-1:0] minutes,
`ifdef DIGITAL_CLOCK_12H_EN
  output logic [TIME_W-1:0] hours,
  output logic              pm
`else
  output logic [TIME_W-1:0] hours
`endif
);

  logic [3:0]  btn, btn_q, press;
  logic        sec_wrap, min_wrap, unused_hour_wrap;
  logic        min_up, min_down, hour_up, hour_down;
  time_field_t hour_cnt;

  assign btn = {hour_dec, hour_inc, min_dec, min_inc};

  // History tracks buttons in both modes so a button held across entry to
  // set mode must be released before it can act.
  always_ff @(posedge Clk_1sec) begin
    if (!reset) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = btn & ~btn_q;

  // Run mode chains carries; set mode uses presses only, with no carry.
  assign min_up    = clock_enable ? sec_wrap : press[0];
  assign min_down  = !clock_enable && press[1];
  assign hour_up   = clock_enable ? min_wrap : press[2];
  assign hour_down = !clock_enable && press[3];

  clock_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk     (Clk_1sec),
    .clear_n (reset),
    .inc     (clock_enable),
    .dec     (1'b0),
    .count   (seconds),
    .wrap    (sec_wrap)
  );

  clock_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk     (Clk_1sec),
    .clear_n (reset),
    .inc     (min_up),
    .dec     (min_down),
    .count   (minutes),
    .wrap    (min_wrap)
  );

  clock_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk     (Clk_1sec),
    .clear_n (reset),
    .inc     (hour_up),
    .dec     (hour_down),
    .count   (hour_cnt),
    .wrap    (unused_hour_wrap)
  );

`ifdef DIGITAL_CLOCK_12H_EN
  assign hours = to_12h(hour_cnt);
  assign pm    = (hour_cnt >= time_field_t'(12));
`else
  assign hours = hour_cnt;
`endif

endmodule

// File: tb/tb_digital_clock.sv
// Self-checking bench for digital_clock: directed scenarios plus random
// stimulus against a time-in-seconds reference model.
module tb_digital_clock;

  logic       Clk_1sec = 1'b0;
  logic       reset = 1'b0;
  logic       clock_enable = 1'b0;
  logic       min_inc = 1'b0, min_dec = 1'b0, hour_inc = 1'b0, hour_dec = 1'b0;
  logic [5:0] seconds, minutes, hours;
`ifdef DIGITAL_CLOCK_12H_EN
  logic       pm;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: time as seconds since midnight plus button history.
  int       t = 0;
  bit [3:0] hist = '0;

  digital_clock dut (
    .Clk_1sec     (Clk_1sec),
    .reset        (reset),
    .clock_enable (clock_enable),
    .min_inc      (min_inc),
    .min_dec      (min_dec),
    .hour_inc     (hour_inc),
    .hour_dec     (hour_dec),
    .seconds      (seconds),
    .minutes      (minutes),
`ifdef DIGITAL_CLOCK_12H_EN
    .hours        (hours),
    .pm           (pm)
`else
    .hours        (hours)
`endif
  );

  always #5 Clk_1sec = ~Clk_1sec;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int hmap(input int h);
`ifdef DIGITAL_CLOCK_12H_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
`else
    return h;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // b = {hour_dec, hour_inc, min_dec, min_inc}
  task automatic model_edge(input bit rst_n, input bit ce, input bit [3:0] b);
    int h, m, s;
    bit [3:0] p;
    if (!rst_n) begin
      t = 0;
      hist = '0;
      return;
    end
    if (ce) begin
      t = (t + 1) % 86400;
    end else begin
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      p = b & ~hist;
      m = (m + int'(p[0]) - int'(p[1]) + 60) % 60;
      h = (h + int'(p[2]) - int'(p[3]) + 24) % 24;
      t = h * 3600 + m * 60 + s;
    end
    hist = b;
  endtask

  task automatic step(input bit rst_n, input bit ce, input bit [3:0] b);
    @(negedge Clk_1sec);
    reset = rst_n;
    clock_enable = ce;
    {hour_dec, hour_inc, min_dec, min_inc} = b;
    @(posedge Clk_1sec);
    model_edge(rst_n, ce, b);
    #1;
    chk("seconds", seconds, t % 60);
    chk("minutes", minutes, (t / 60) % 60);
    chk("hours", hours, hmap(t / 3600));
`ifdef DIGITAL_CLOCK_12H_EN
    chk("pm", pm, (t / 3600) >= 12);
`endif
  endtask

  task automatic press(input bit [3:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, b);
      step(1'b1, 1'b0, 4'b0000);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'b0000);
  endtask

  initial begin
    bit [3:0] b;

    // Reset from scrambled state, then count 1, 2, 3.
    step(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 4'($urandom));
    step(1'b0, 1'($urandom), 4'($urandom));
    chk("reset_sec", seconds, 0);
    chk("reset_min", minutes, 0);
    chk("reset_hour", hours, hmap(0));
`ifdef DIGITAL_CLOCK_12H_EN
    chk("reset_hour12", hours, 12);
    chk("reset_pm", pm, 0);
`endif
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 4'b0000);
      chk("count_after_reset", seconds, i);
    end

    // 23:59:58 -> 23:59:59 -> 00:00:00.
    step(1'b0, 1'b0, 4'b0000);
    press(4'b1000, 1);
    chk("hour_dec_wrap", hours, hmap(23));
    press(4'b0010, 1);
    chk("min_dec_wrap", minutes, 59);
    chk("min_dec_no_borrow", hours, hmap(23));
    run(58);
    chk("pre_wrap_sec", seconds, 58);
    run(1);
    chk("sec59", seconds, 59);
    run(1);
    chk("midnight_sec", seconds, 0);
    chk("midnight_min", minutes, 0);
    chk("midnight_hour", hours, hmap(0));
    press(4'b1000, 1);
    chk("hour_dec_0_to_23", hours, hmap(23));
    press(4'b0100, 1);
    chk("hour_inc_23_to_0", hours, hmap(0));

    // 00:59:59 -> 01:00:00.
    step(1'b0, 1'b0, 4'b0000);
    press(4'b0010, 1);
    run(59);
    run(1);
    chk("hour_carry_h", hours, hmap(1));
    chk("hour_carry_m", minutes, 0);

    // 10:20:30 frozen, then min_inc held for 4 edges.
    step(1'b0, 1'b0, 4'b0000);
    press(4'b0100, 10);
    press(4'b0001, 20);
    run(30);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0000);
    chk("frozen_sec", seconds, 30);
    chk("frozen_min", minutes, 20);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'b0001);
    chk("held_min_inc", minutes, 21);
    step(1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b0011);
    chk("inc_dec_cancel", minutes, 21);
    step(1'b1, 1'b0, 4'b0000);

    // 05:59 with min_inc + hour_inc together -> 06:00.
    step(1'b0, 1'b0, 4'b0000);
    press(4'b0100, 5);
    press(4'b0010, 1);
    step(1'b1, 1'b0, 4'b0101);
    chk("joint_min", minutes, 0);
    chk("joint_hour", hours, hmap(6));
    step(1'b1, 1'b0, 4'b0000);

    // Buttons ignored in run mode; a held button does not act on mode entry.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 4'($urandom));
    step(1'b1, 1'b1, 4'b0001);
    step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 4'b0000);

    // Random mix of modes, held/toggled buttons and occasional reset.
    b = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) b = 4'($urandom);
      step($urandom_range(63) != 0, $urandom_range(2) != 0, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digital_clock.md
Name: digital_clock

Overview:
- 24-hour time-of-day counter (hours:minutes:seconds) clocked by a 1 Hz tick clock.
- Counts time while `clock_enable` is high.
- While `clock_enable` is low, time is frozen and the user buttons set minutes and hours.
- Sits between the 1 Hz divider and the display/BCD-conversion logic of the watch chip.

Parameters:
- none. All moduli are fixed constants from the shared package.

Ports:
- `Clk_1sec`  in  1  1 Hz clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `Clk_1sec`.
- `clock_enable`  in  1  1 = run (timekeeping); 0 = set mode (time frozen, buttons active).
- `min_inc`  in  1  minute-up button, level from debouncer.
- `min_dec`  in  1  minute-down button.
- `hour_inc`  in  1  hour-up button.
- `hour_dec`  in  1  hour-down button.
- `seconds`  out  6  binary 0..59, registered.
- `minutes`  out  6  binary 0..59, registered.
- `hours`  out  6  binary 0..23, registered (upper bit always 0 in 24 h mode).

Behaviour:
- Single clock domain. Every register updates only on the rising edge of `Clk_1sec`.
- Reset: `reset`=0 at an edge forces the following to 0, overriding all other inputs:
  - `seconds`, `minutes`, `hours`.
  - All button-history registers.
- Reset asserted mid-count clears on that same edge, so the outputs read 00:00:00 in the next cycle.
- Run mode (`clock_enable`=1):
  - `seconds` +1 each edge.
  - 59 → 0 with carry to minutes; `minutes` 59 → 0 with carry to hours; `hours` 23 → 0.
  - 23:59:59 → 00:00:00 in one edge.
  - Buttons are ignored, but their history registers still track them.
- Set mode (`clock_enable`=0):
  - `seconds` holds its value.
  - Each button is rising-edge detected against a registered copy of itself. A press acts once, on the edge where the button is 1 and the stored copy is 0. Holding a button produces no further steps.
  - `min_inc` press: `minutes` +1, 59 → 0, no carry into hours.
  - `min_dec` press: `minutes` −1, 0 → 59, no borrow from hours.
  - `hour_inc` press: `hours` +1, 23 → 0.
  - `hour_dec` press: `hours` −1, 0 → 23.
  - Inc and dec press on the same field in the same edge: that field unchanged.
  - Minute and hour presses in the same edge: both applied independently.
- Mode change:
  - A 1 → 0 transition of `clock_enable` takes effect on the same edge; no increment occurs on that edge.
  - A button already held when set mode is entered does not act until it is released and pressed again.
- Latency:
  - Output reflects an input one edge after sampling.
  - No combinational path from inputs to outputs.
- Counter values never leave their legal range. Out-of-range states are unreachable.

Optional Feature:
- Macro: `DIGITAL_CLOCK_12H_EN`.
- When defined:
  - Adds output port `pm` (1 bit). `pm`=1 when the internal 24 h hour ≥ 12.
  - `hours` output is mapped combinationally from an internal 0..23 register: 0 → 12, 1..12 → same, 13..23 → minus 12.
  - Counting and button arithmetic still operate on the internal 0..23 value.
  - Reset gives 12:00:00 with `pm`=0.
- When undefined: no `pm` port; `hours` outputs 0..23 directly.

Decomposition:
- Package `digital_clock_pkg` holds:
  - `TIME_W`=6.
  - `SEC_MOD`=60, `MIN_MOD`=60, `HOUR_MOD`=24.
  - typedef `time_field_t` = logic [5:0].
- Natural sub-module `clock_mod_counter`:
  - Parameterized modulo-N up/down counter with synchronous active-low clear.
  - Inputs: `inc`, `dec`. Outputs: count and wrap/carry.
  - Instantiated three times: seconds, minutes, hours.
- Edge detection and mode gating live in the top module.

Test Plan:
- `reset`=0 for 1 edge with random prior state → 00:00:00; with `clock_enable`=1 after release, the next 3 edges give `seconds` 1, 2, 3.
- Run from 23:59:58, `clock_enable`=1 → 23:59:59, then 00:00:00. Also 00:59:59 → 01:00:00.
- `clock_enable`=0 at 10:20:30, 5 edges idle → time constant; `min_inc` held high 4 edges → `minutes`=21 only.
- Set mode: `min_dec` at `minutes`=0 → 59 with `hours` unchanged; `hour_inc` at 23 → 0; `hour_dec` at 0 → 23.
- Set mode: `min_inc`+`min_dec` pressed together → no change; `min_inc`+`hour_inc` together from 05:59 → 06:00, with no carry, so `minutes` wraps to 0 and `hours` 5 → 6 from its own press.
- Run mode with buttons toggling → buttons ignored. With `DIGITAL_CLOCK_12H_EN`: after reset, `hours`=12, `pm`=0; internal 13 → `hours`=1, `pm`=1.
